// File: rtl/score_keeper_if.sv
// score_keeper_if: button/miss/timer inputs and score/state outputs of score_keeper.
interface score_keeper_if;
   logic       start_i;
   logic       miss1_i;
   logic       miss2_i;
   logic       time_up_i;
   logic       stop_o;
   logic [3:0] score1_o;
   logic [3:0] score2_o;
   logic [1:0] game_state_o;
   logic [1:0] winner_o;
   modport slave (
      input  start_i, miss1_i, miss2_i, time_up_i,
      output stop_o, score1_o, score2_o, game_state_o, winner_o
   );
   modport master (
      output start_i, miss1_i, miss2_i, time_up_i,
      input  stop_o, score1_o, score2_o, game_state_o, winner_o
   );
endinterface

// File: rtl/score_keeper.sv
// score_keeper: pong game FSM with saturating scores, serve/game-over hold timer and winner flag.
// Defining SCORE_WIN_EN ends a game as soon as a player reaches WIN_SCORE.
module score_keeper #(
   parameter int SERVE_CYCLES = 100000000,
   parameter int WIN_SCORE    = 7
) (
   input logic          clk,
   input logic          rst_n,
   score_keeper_if.slave bus
);
   localparam int CW = (SERVE_CYCLES > 1) ? $clog2(SERVE_CYCLES) : 1;
   localparam logic [CW-1:0] LOAD = CW'(SERVE_CYCLES - 1);
   localparam logic [3:0] WIN = 4'(WIN_SCORE);
`ifdef SCORE_WIN_EN
   localparam bit WIN_EN = 1'b1;
`else
   localparam bit WIN_EN = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, SERVE = 2'd2, OVER = 2'd3} state_t;

   state_t        state_q, state_d;
   logic [3:0]    s1_q, s1_d, s2_q, s2_d;
   logic [1:0]    win_q, win_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          m1_q, m2_q, stop_q;
   logic          e1, e2, hit1, hit2, won, entry;

   always_comb begin
      e1      = bus.miss1_i & ~m1_q;
      e2      = bus.miss2_i & ~m2_q;
      hit1    = e2 & ~e1;
      hit2    = e1 & ~e2;
      state_d = state_q;
      s1_d    = s1_q;
      s2_d    = s2_q;
      won     = 1'b0;
      case (state_q)
         IDLE: if (bus.start_i) begin
            state_d = PLAY;
            s1_d    = '0;
            s2_d    = '0;
         end
         PLAY: begin
            if (hit1 && s1_q != 4'd9) s1_d = s1_q + 4'd1;
            if (hit2 && s2_q != 4'd9) s2_d = s2_q + 4'd1;
            won     = WIN_EN && ((s1_d != s1_q && s1_d == WIN) || (s2_d != s2_q && s2_d == WIN));
            state_d = (bus.time_up_i || won) ? OVER : (e1 || e2) ? SERVE : PLAY;
         end
         SERVE: state_d = bus.time_up_i ? OVER : (cnt_q == '0 && bus.start_i) ? PLAY : SERVE;
         default: state_d = (cnt_q == '0) ? IDLE : OVER;
      endcase
      entry = (state_d != state_q) && (state_d == SERVE || state_d == OVER);
      cnt_d = entry ? LOAD : (cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
      // {p2 >= p1, p1 >= p2} yields 01 / 10 / 11 for p1 win / p2 win / tie
      win_d = (state_d != OVER) ? 2'b00 : (state_q == OVER) ? win_q : {s2_d >= s1_d, s1_d >= s2_d};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         s1_q    <= '0;
         s2_q    <= '0;
         win_q   <= '0;
         cnt_q   <= '0;
         m1_q    <= 1'b0;
         m2_q    <= 1'b0;
         stop_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         s1_q    <= s1_d;
         s2_q    <= s2_d;
         win_q   <= win_d;
         cnt_q   <= cnt_d;
         m1_q    <= bus.miss1_i;
         m2_q    <= bus.miss2_i;
         stop_q  <= state_d != PLAY;
      end
   end

   assign bus.stop_o       = stop_q;
   assign bus.score1_o     = s1_q;
   assign bus.score2_o     = s2_q;
   assign bus.game_state_o = state_q;
   assign bus.winner_o     = win_q;
endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper: directed and random stimulus against a cycle-count reference model, queue scoreboard.
module tb_score_keeper;
   localparam int SC = 8;
   localparam int WS = 3;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   score_keeper_if bus ();
   score_keeper #(.SERVE_CYCLES(SC), .WIN_SCORE(WS)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   typedef struct {int ph; int s1; int s2; int stop; int win;} exp_t;
   exp_t q[$];
   int n_chk = 0;
   int n_fail = 0;

   // reference: phase 0 idle, 1 play, 2 serve, 3 over; age = cycles spent in current phase
   int ph = 0, s1 = 0, s2 = 0, win = 0, age = 0;
   bit p1 = 0, p2 = 0;

   function automatic void chk(string nm, int act, int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endfunction

   task automatic model(bit st, bit m1, bit m2, bit tu);
      bit e1, e2, scored, expired;
      int nph;
      e1 = m1 && !p1;
      e2 = m2 && !p2;
      p1 = m1;
      p2 = m2;
      expired = age >= SC - 1;
      scored = 0;
      nph = ph;
      if (ph == 0) begin
         if (st) begin s1 = 0; s2 = 0; nph = 1; end
      end else if (ph == 1) begin
         if (e2 && !e1 && s1 < 9) begin s1++; scored = scored || s1 == WS; end
         if (e1 && !e2 && s2 < 9) begin s2++; scored = scored || s2 == WS; end
`ifndef SCORE_WIN_EN
         scored = 0;
`endif
         nph = (tu || scored) ? 3 : (e1 || e2) ? 2 : 1;
      end else if (ph == 2) nph = tu ? 3 : (expired && st) ? 1 : 2;
      else nph = expired ? 0 : 3;
      age = (nph != ph) ? 0 : age + 1;
      if (nph == 3 && ph != 3) win = (s1 > s2) ? 1 : (s2 > s1) ? 2 : 3;
      else if (nph != 3) win = 0;
      ph = nph;
      q.push_back('{ph, s1, s2, int'(ph != 1), win});
   endtask

   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         chk("game_state", bus.game_state_o, e.ph);
         chk("score1", bus.score1_o, e.s1);
         chk("score2", bus.score2_o, e.s2);
         chk("stop", bus.stop_o, e.stop);
         chk("winner", bus.winner_o, e.win);
      end
   end

   task automatic cyc(bit st, bit m1, bit m2, bit tu);
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      bus.start_i = st;
      bus.miss1_i = m1;
      bus.miss2_i = m2;
      bus.time_up_i = tu;
      model(st, m1, m2, tu);
   endtask

   task automatic do_reset(bit m1, bit m2);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      bus.start_i = 1'b0;
      bus.miss1_i = m1;
      bus.miss2_i = m2;
      bus.time_up_i = 1'b0;
      #1;
      chk("rst_state", bus.game_state_o, 0);
      chk("rst_score1", bus.score1_o, 0);
      chk("rst_score2", bus.score2_o, 0);
      chk("rst_stop", bus.stop_o, 1);
      chk("rst_winner", bus.winner_o, 0);
      ph = 0; s1 = 0; s2 = 0; win = 0; age = 0; p1 = 0; p2 = 0;
      q.push_back('{0, 0, 0, 1, 0});
   endtask

   task automatic serve_wait();
      repeat (SC) cyc(1, 0, 0, 0);
   endtask

   initial begin
      bit m1, m2;
      bus.start_i = 0;
      bus.miss1_i = 0;
      bus.miss2_i = 0;
      bus.time_up_i = 0;
      do_reset(0, 0);
      cyc(0, 0, 0, 0);
      cyc(1, 0, 0, 0);
      repeat (5) cyc(0, 0, 1, 0);
      cyc(0, 0, 0, 0);
      serve_wait();
      cyc(1, 1, 0, 0);
      repeat (SC) cyc(1, 1, 0, 0);
      cyc(0, 0, 0, 0);
      cyc(0, 1, 1, 0);
      cyc(0, 0, 0, 0);
      serve_wait();
      cyc(0, 0, 1, 0);
      cyc(0, 0, 0, 0);
      serve_wait();
      cyc(0, 1, 0, 1);
      repeat (SC + 1) cyc(1, 0, 0, 0);
      cyc(1, 0, 0, 0);
      repeat (2) begin cyc(0, 0, 1, 0); cyc(0, 0, 0, 0); serve_wait(); end
      cyc(0, 0, 1, 0);
      repeat (SC + 2) cyc(0, 0, 0, 0);
      cyc(1, 0, 0, 0);
      cyc(0, 1, 0, 0);
      cyc(0, 1, 0, 0);
      do_reset(1, 0);
      cyc(1, 1, 0, 0);
      cyc(0, 1, 0, 0);
      cyc(0, 0, 0, 0);
      m1 = 0;
      m2 = 0;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 499) == 0) do_reset(m1, m2);
         if ($urandom_range(0, 5) == 0) m1 = !m1;
         if ($urandom_range(0, 5) == 0) m2 = !m2;
         cyc($urandom_range(0, 3) == 0, m1, m2, $urandom_range(0, 149) == 0);
      end
      @(negedge clk);
      #2;
      chk("drain", q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/score_keeper.md
SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 The block SHALL take parameter SERVE_CYCLES, default 100000000, meaning clk cycles in the post-miss and post-game hold windows (2 s at 50 MHz).
REQ-002 The block SHALL take parameter WIN_SCORE, default 7, meaning the point total that ends a game when SCORE_WIN_EN is defined.
REQ-003 clk  input  1  system clock; the block SHALL use one clock only, with all state on its rising edge.
REQ-004 rst  input  1  reset; the block SHALL reset asynchronously on rst low (active-low).
REQ-005 start  input  1  player start/serve button, level-sampled, already synchronised.
REQ-006 miss1  input  1  ball passed paddle 1, level from ball engine, may stay high many cycles.
REQ-007 miss2  input  1  ball passed paddle 2, same semantics as miss1.
REQ-008 time_up  input  1  countdown timer reached 0:00, level.
REQ-009 stop  output  1  freeze ball engine; high in every state except PLAY.
REQ-010 score1  output  4  player 1 points, binary 0..9, feeds dot-matrix display.
REQ-011 score2  output  4  player 2 points, binary 0..9.
REQ-012 game_state  output  2  IDLE=0, PLAY=1, SERVE=2, OVER=3.
REQ-013 winner  output  2  00 none, 01 player 1, 10 player 2, 11 tie; valid only in OVER.

Function
REQ-014 All outputs SHALL be registered; an input event sampled on edge N SHALL be visible on outputs after edge N+1 and no later.
REQ-015 miss1/miss2 SHALL be rising-edge detected against a registered copy; a held-high miss SHALL count once.
REQ-016 IDLE: on start=1 the block SHALL clear both scores and enter PLAY; otherwise it SHALL hold scores unchanged.
REQ-017 PLAY, miss1 edge only: score2 SHALL increment and state SHALL go to SERVE.
REQ-018 PLAY, miss2 edge only: score1 SHALL increment and state SHALL go to SERVE.
REQ-019 PLAY, miss1 and miss2 edges in the same cycle: scores SHALL be unchanged and state SHALL go to SERVE.
REQ-020 PLAY, time_up=1: state SHALL go to OVER; a miss edge in the same cycle SHALL still score (REQ-017..019) and OVER SHALL take precedence over SERVE.
REQ-021 Scores SHALL saturate at 9; an increment at 9 SHALL leave 9.
REQ-022 Miss edges outside PLAY SHALL be ignored, but the edge-detect register SHALL update every cycle.
REQ-023 On entry to SERVE or OVER, a down-counter SHALL load SERVE_CYCLES-1 and decrement once per cycle to 0, then hold at 0.
REQ-024 SERVE: when the counter is 0 and start=1, the block SHALL enter PLAY; start before expiry SHALL be ignored; time_up=1 SHALL go to OVER immediately.
REQ-025 OVER: when the counter is 0, the block SHALL enter IDLE with scores held; start SHALL be ignored in OVER.
REQ-026 winner SHALL be computed from final scores on entry to OVER, held through OVER, and be 00 in every other state.
REQ-027 The counter SHALL be wide enough for SERVE_CYCLES-1 ($clog2), minimum 1 bit.

Reset
REQ-028 rst low SHALL force IDLE, stop=1, score1=score2=0, winner=00, counter=0, and miss edge registers=0, asynchronously, including mid-SERVE or mid-OVER.
REQ-029 After rst deasserts, a miss input already high SHALL NOT count as an edge.

Configuration
REQ-030 With macro SCORE_WIN_EN defined, a score increment that reaches WIN_SCORE SHALL send PLAY directly to OVER instead of SERVE, and winner SHALL reflect that player.
REQ-031 Without SCORE_WIN_EN, only time_up SHALL end a game, and scores SHALL saturate per REQ-021.

Verification (SERVE_CYCLES=8, WIN_SCORE=3)
REQ-032 Reset, start pulse, miss2 high for 5 cycles -> score1=1 exactly once, state SERVE, stop=1.
REQ-033 In SERVE, start held from entry -> PLAY is reached exactly 8 cycles after SERVE entry, not earlier.
REQ-034 In PLAY, miss1 and miss2 rise on the same edge -> scores unchanged, state SERVE.
REQ-035 Scores 2-1 and time_up asserted together with a miss1 edge -> score 2-2, state OVER, winner=11, IDLE 8 cycles later.
REQ-036 With SCORE_WIN_EN and scores 2-0, a miss2 edge -> score1=3, state OVER, winner=01; without SCORE_WIN_EN -> state SERVE.
REQ-037 rst low mid-SERVE with scores 4-5 -> IDLE, scores 0-0, stop=1 immediately, without waiting for a clock edge.
